// File: rtl/simon_decrypt.sv
// Iterative Simon 32/64 decryption core, one round per cycle.
// Optional key cache: define SIMON_DECRYPT_KEYCACHE_EN.
module simon_decrypt #(
  parameter int N         = 32,
  parameter int KEY_WORDS = 4,
  parameter int ROUNDS    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      start,
  input  logic [N-1:0]              ciphertext,
  input  logic [16*KEY_WORDS-1:0]   key,
  output logic [N-1:0]              plaintext,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DECRYPT,
    DONE
  } state_t;

  localparam logic [4:0] R_LAST = 5'(ROUNDS - 1);
  localparam logic [4:0] E_LAST = 5'(ROUNDS - KEY_WORDS - 1);
  // z0 bits 0..31; later bits are never needed for 32 rounds
  localparam logic [0:31] Z0 = 32'b1111_1010_0010_0101_0110_0001_1100_1101;

  function automatic logic [15:0] f_rnd(input logic [15:0] v);
    return ({v[14:0], v[15]} & {v[7:0], v[15:8]})
         ^ {v[13:0], v[15:14]};
  endfunction

  function automatic logic [15:0] ks_tmp(
    input logic [15:0] k1,
    input logic [15:0] k3
  );
    logic [15:0] t;
    t = {k3[2:0], k3[15:3]} ^ k1;
    return t ^ {t[0], t[15:1]};
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [63:0] w_q, w_d;
  logic [31:0] pt_q, pt_d;

  logic [4:0]  zi_inv;
  logic [15:0] k_fwd;
  logic [15:0] k_inv;
  logic [15:0] y_new;

`ifdef SIMON_DECRYPT_KEYCACHE_EN
  logic [63:0] ck_key_q, ck_key_d;
  logic [63:0] ck_win_q, ck_win_d;
  logic        ck_vld_q, ck_vld_d;
`endif

  // Window below r=4 fills with unused words; z index wraps harmlessly
  assign zi_inv = cnt_q - 5'd4;
  assign k_fwd  = ~w_q[15:0] ^ ks_tmp(w_q[31:16], w_q[63:48])
                ^ {15'd0, Z0[cnt_q]} ^ 16'd3;
  assign k_inv  = ~(w_q[63:48] ^ ks_tmp(w_q[15:0], w_q[47:32])
                ^ {15'd0, Z0[zi_inv]} ^ 16'd3);
  assign y_new  = x_q ^ f_rnd(y_q) ^ w_q[63:48];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    pt_d    = pt_q;
`ifdef SIMON_DECRYPT_KEYCACHE_EN
    ck_key_d = ck_key_q;
    ck_win_d = ck_win_q;
    ck_vld_d = ck_vld_q;
`endif
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            x_d = ciphertext[31:16];
            y_d = ciphertext[15:0];
`ifdef SIMON_DECRYPT_KEYCACHE_EN
            if (ck_vld_q && key == ck_key_q) begin
              w_d     = ck_win_q;
              cnt_d   = R_LAST;
              state_d = DECRYPT;
            end else begin
              w_d      = key;
              cnt_d    = 5'd0;
              state_d  = EXPAND;
              ck_key_d = key;
              ck_vld_d = 1'b0;
            end
`else
            w_d     = key;
            cnt_d   = 5'd0;
            state_d = EXPAND;
`endif
          end
        end
        EXPAND: begin
          w_d   = {k_fwd, w_q[63:16]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == E_LAST) begin
            cnt_d   = R_LAST;
            state_d = DECRYPT;
`ifdef SIMON_DECRYPT_KEYCACHE_EN
            ck_win_d = {k_fwd, w_q[63:16]};
            ck_vld_d = 1'b1;
`endif
          end
        end
        DECRYPT: begin
          x_d = y_q;
          y_d = y_new;
          if (cnt_q != 5'd0) begin
            w_d   = {w_q[47:0], k_inv};
            cnt_d = cnt_q - 5'd1;
          end else begin
            pt_d    = {y_q, y_new};
            state_d = DONE;
          end
        end
        DONE: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      pt_q    <= pt_d;
    end
  end

`ifdef SIMON_DECRYPT_KEYCACHE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ck_key_q <= '0;
      ck_win_q <= '0;
      ck_vld_q <= 1'b0;
    end else begin
      ck_key_q <= ck_key_d;
      ck_win_q <= ck_win_d;
      ck_vld_q <= ck_vld_d;
    end
  end
`endif

  assign plaintext = pt_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_simon_decrypt.sv
// Self-checking bench for simon_decrypt with a Simon 32/64
// reference model (encrypt and decrypt) built from the cipher rules.
module tb_simon_decrypt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ciphertext = '0;
  logic [63:0] key = '0;
  logic [31:0] plaintext;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] KAT_CT  = 32'hC69B_E9BB;
  localparam logic [31:0] KAT_PT  = 32'h6565_6877;
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

`ifdef SIMON_DECRYPT_KEYCACHE_EN
  localparam bit KC = 1'b1;
`else
  localparam bit KC = 1'b0;
`endif

  bit          cache_vld_m = 1'b0;
  logic [63:0] cache_key_m = '0;

  simon_decrypt dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .ciphertext (ciphertext),
    .key        (key),
    .plaintext  (plaintext),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rotl(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [15:0] rotr(input logic [15:0] v, input int s);
    return rotl(v, 16 - s);
  endfunction

  function automatic logic [15:0] fr(input logic [15:0] v);
    return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
  endfunction

  typedef logic [15:0] ks_t [32];

  function automatic ks_t sched(input logic [63:0] k);
    ks_t ks;
    logic [15:0] tmp;
    for (int i = 0; i < 4; i++) ks[i] = k[16*i +: 16];
    for (int i = 0; i < 28; i++) begin
      tmp = rotr(ks[i+3], 3) ^ ks[i+1];
      tmp = tmp ^ rotr(tmp, 1);
      ks[i+4] = ~ks[i] ^ tmp ^ {15'd0, Z0[61-i]} ^ 16'd3;
    end
    return ks;
  endfunction

  function automatic logic [31:0] ref_enc(input logic [63:0] k,
                                          input logic [31:0] p);
    ks_t ks;
    logic [15:0] x, y, t;
    ks = sched(k);
    x = p[31:16];
    y = p[15:0];
    for (int r = 0; r < 32; r++) begin
      t = x;
      x = y ^ fr(x) ^ ks[r];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic logic [31:0] ref_dec(input logic [63:0] k,
                                          input logic [31:0] c);
    ks_t ks;
    logic [15:0] x, y, t;
    ks = sched(k);
    x = c[31:16];
    y = c[15:0];
    for (int r = 31; r >= 0; r--) begin
      t = y;
      y = x ^ fr(y) ^ ks[r];
      x = t;
    end
    return {x, y};
  endfunction

  function automatic int exp_lat(input logic [63:0] k);
    return (KC && cache_vld_m && k == cache_key_m) ? 33 : 61;
  endfunction

  // Runs one operation; en is low during cycles [s1,s1+l1) and
  // [s2,s2+l2); an extra start with xct is driven in cycle xc.
  task automatic run_op(
    input  logic [63:0] k,
    input  logic [31:0] ct,
    input  int          s1,
    input  int          l1,
    input  int          s2,
    input  int          l2,
    input  int          xc,
    input  logic [31:0] xct,
    output logic [31:0] pt,
    output int          dcyc,
    output int          ndone,
    output int          busy_bad
  );
    bit stall;
    @(negedge clk);
    key = k;
    ciphertext = ct;
    en = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    key = {$urandom, $urandom};
    ciphertext = $urandom;
    pt = '0;
    dcyc = 0;
    ndone = 0;
    busy_bad = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (dcyc == 0) begin
          dcyc = c;
          pt = plaintext;
        end
      end
      if (busy !== ((ndone == 0) || (c == dcyc))) busy_bad++;
      stall = (c >= s1 && c < s1 + l1) || (c >= s2 && c < s2 + l2);
      en = !stall;
      start = (c == xc);
      if (c == xc) ciphertext = xct;
      if (dcyc != 0 && c >= dcyc + 3) break;
    end
    en = 1'b1;
    start = 1'b0;
    cache_vld_m = 1'b1;
    cache_key_m = k;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b want=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b want=0", done);
    end
    checks++;
    if (plaintext !== 32'h0) begin
      failures++;
      $display("FAIL reset_pt got=%h want=0", plaintext);
    end
    rst = 1'b0;
    cache_vld_m = 1'b0;
  endtask

  task automatic test_model;
    checks++;
    if (ref_enc(KAT_KEY, KAT_PT) !== KAT_CT) begin
      failures++;
      $display("FAIL model_kat got=%h want=%h",
               ref_enc(KAT_KEY, KAT_PT), KAT_CT);
    end
  endtask

  task automatic test_known_answer;
    logic [31:0] pt;
    int d, n, bb, lat;
    lat = exp_lat(KAT_KEY);
    run_op(KAT_KEY, KAT_CT, 0, 0, 0, 0, -1, '0, pt, d, n, bb);
    checks++;
    if (pt !== KAT_PT) begin
      failures++;
      $display("FAIL kat_pt got=%h want=%h", pt, KAT_PT);
    end
    checks++;
    if (d != lat) begin
      failures++;
      $display("FAIL kat_latency got=%0d want=%0d", d, lat);
    end
    checks++;
    if (n != 1 || bb != 0) begin
      failures++;
      $display("FAIL kat_pulse done_count=%0d busy_err=%0d want 1/0", n, bb);
    end
  endtask

  task automatic test_en_gate;
    @(negedge clk);
    key = KAT_KEY;
    ciphertext = KAT_CT;
    en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    en = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL en_gate_start busy got=%b want=0", busy);
    end
  endtask

  task automatic test_stall;
    logic [31:0] pt;
    int d, n, bb, lat;
    lat = exp_lat(KAT_KEY) + 8;
    run_op(KAT_KEY, KAT_CT, 5, 5, 35, 3, -1, '0, pt, d, n, bb);
    checks++;
    if (pt !== KAT_PT || d != lat) begin
      failures++;
      $display("FAIL stall pt=%h cyc=%0d want pt=%h cyc=%0d",
               pt, d, KAT_PT, lat);
    end
    checks++;
    if (n != 1 || bb != 0) begin
      failures++;
      $display("FAIL stall_pulse done_count=%0d busy_err=%0d want 1/0", n, bb);
    end
  endtask

  task automatic test_busy_protect;
    logic [31:0] pt;
    int d, n, bb, lat;
    lat = exp_lat(KAT_KEY);
    run_op(KAT_KEY, KAT_CT, 0, 0, 0, 0, 10, 32'h1234_5678, pt, d, n, bb);
    checks++;
    if (pt !== KAT_PT || d != lat) begin
      failures++;
      $display("FAIL busy_protect pt=%h cyc=%0d want pt=%h cyc=%0d",
               pt, d, KAT_PT, lat);
    end
    checks++;
    if (n != 1 || bb != 0) begin
      failures++;
      $display("FAIL busy_protect_pulse done_count=%0d busy_err=%0d", n, bb);
    end
  endtask

  task automatic test_done_start;
    logic [31:0] pt;
    int d, n, bb, lat;
    lat = exp_lat(KAT_KEY);
    run_op(KAT_KEY, KAT_CT, 0, 0, 0, 0, lat, 32'hDEAD_BEEF, pt, d, n, bb);
    checks++;
    if (n != 1 || bb != 0 || pt !== KAT_PT) begin
      failures++;
      $display("FAIL done_start done_count=%0d busy_err=%0d pt=%h",
               n, bb, pt);
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] pt;
    int d, n, bb;
    @(negedge clk);
    key = KAT_KEY;
    ciphertext = KAT_CT;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cache_vld_m = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || plaintext !== 32'h0) begin
      failures++;
      $display("FAIL abort busy=%b done=%b pt=%h want 0/0/0",
               busy, done, plaintext);
    end
    run_op(KAT_KEY, KAT_CT, 0, 0, 0, 0, -1, '0, pt, d, n, bb);
    checks++;
    if (pt !== KAT_PT || d != 61 || n != 1) begin
      failures++;
      $display("FAIL abort_restart pt=%h cyc=%0d n=%0d want %h/61/1",
               pt, d, n, KAT_PT);
    end
  endtask

  task automatic test_round_trip;
    logic [63:0] k;
    logic [31:0] p, c, pt;
    int d, n, bb, lat, bad;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      k = {$urandom, $urandom};
      p = $urandom;
      c = ref_enc(k, p);
      lat = exp_lat(k);
      run_op(k, c, 0, 0, 0, 0, -1, '0, pt, d, n, bb);
      checks++;
      if (pt !== p || ref_dec(k, c) !== p || d != lat || n != 1) begin
        failures++;
        bad++;
        if (bad <= 5)
          $display("FAIL round_trip[%0d] key=%h got=%h want=%h cyc=%0d/%0d",
                   i, k, pt, p, d, lat);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] k;
    logic [31:0] pt, c2;
    int d, n, bb;
    k = {$urandom, $urandom};
    c2 = ref_enc(KAT_KEY, 32'h0);
    run_op(KAT_KEY, KAT_CT, 0, 0, 0, 0, -1, '0, pt, d, n, bb);
    run_op(KAT_KEY, c2, 0, 0, 0, 0, -1, '0, pt, d, n, bb);
    checks++;
    if (pt !== 32'h0 || d != (KC ? 33 : 61)) begin
      failures++;
      $display("FAIL b2b_same_key pt=%h cyc=%0d want 00000000/%0d",
               pt, d, KC ? 33 : 61);
    end
    run_op(k, ref_enc(k, 32'hA5A5_5A5A), 0, 0, 0, 0, -1, '0, pt, d, n, bb);
    checks++;
    if (pt !== 32'hA5A5_5A5A || d != 61) begin
      failures++;
      $display("FAIL b2b_new_key pt=%h cyc=%0d want a5a55a5a/61", pt, d);
    end
  endtask

  initial begin
    test_reset();
    test_model();
    test_known_answer();
    test_en_gate();
    test_stall();
    test_busy_protect();
    test_done_start();
    test_reset_abort();
    test_back_to_back();
    test_round_trip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
